// File: rtl/draw_pkg.sv
// draw_pkg: shared mode constants, FSM encoding and default screen size for the drawing path
package draw_pkg;
  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;
endpackage

// File: rtl/rect_scan_counter.sv
// rect_scan_counter: row-major (dx, dy) walker over a W x H box; outline mode skips interior columns
module rect_scan_counter
  import draw_pkg::*;
#(
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear,
  input  logic               step,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] height,
  input  logic               mode,
  output logic [COORD_W-1:0] nxt_dx,
  output logic [COORD_W-1:0] nxt_dy,
  output logic               last
);
  logic [COORD_W-1:0] dx_q, dx_d, dy_q, dy_d, w_m1, h_m1;
  logic row_end, edge_row, skip;
  always_comb begin
    w_m1     = width - COORD_W'(1);
    h_m1     = height - COORD_W'(1);
    row_end  = dx_q == w_m1;
    edge_row = dy_q == '0 || dy_q == h_m1;
    // interior outline rows jump straight from the left edge to the right edge
    skip     = mode == MODE_OUTLINE && !edge_row && dx_q == '0;
    nxt_dx   = row_end ? '0 : skip ? w_m1 : dx_q + COORD_W'(1);
    nxt_dy   = row_end ? dy_q + COORD_W'(1) : dy_q;
    last     = row_end && dy_q == h_m1;
    dx_d     = clear ? '0 : step ? nxt_dx : dx_q;
    dy_d     = clear ? '0 : step ? nxt_dy : dy_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end
endmodule

// File: rtl/rect_drawer.sv
// rect_drawer: start/busy/done rectangle rasteriser emitting one clipped pixel per clock
module rect_drawer
  import draw_pkg::*;
#(
  parameter int COORD_W  = 8,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [COORD_W-1:0]  start_x,
  input  logic [COORD_W-1:0]  start_y,
  input  logic [COORD_W-1:0]  width,
  input  logic [COORD_W-1:0]  height,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                mode,
  output logic                busy,
  output logic                plot,
  output logic [COORD_W-1:0]  x_out,
  output logic [COORD_W-1:0]  y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                done
);
  localparam logic [COORD_W:0] SW = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0] SH = (COORD_W+1)'(SCREEN_H);
  state_t state_q, state_d;
  logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] bx, by, ox, oy, nxt_dx, nxt_dy;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic mode_q, mode_d, busy_q, busy_d, plot_q, plot_d, done_q, done_d;
  logic accept, zero, last, visible;
  logic [COORD_W:0] px, py;
  rect_scan_counter #(.COORD_W(COORD_W)) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .clear  (accept),
    .step   (state_q == S_DRAW && !last),
    .width  (w_q),
    .height (h_q),
    .mode   (mode_q),
    .nxt_dx (nxt_dx),
    .nxt_dy (nxt_dy),
    .last   (last)
  );
  always_comb begin
    accept  = state_q == S_IDLE && start;
    zero    = width == '0 || height == '0;
    // the first pixel comes straight from the inputs so it appears the cycle after start
    bx      = accept ? start_x : x0_q;
    by      = accept ? start_y : y0_q;
    ox      = accept ? '0 : nxt_dx;
    oy      = accept ? '0 : nxt_dy;
    px      = {1'b0, bx} + {1'b0, ox};
    py      = {1'b0, by} + {1'b0, oy};
    visible = px < SW && py < SH;
    state_d = state_q;
    x0_d = x0_q;
    y0_d = y0_q;
    w_d = w_q;
    h_d = h_q;
    mode_d = mode_q;
    colour_d = colour_q;
    busy_d = busy_q;
    plot_d = 1'b0;
    done_d = 1'b0;
    x_d = x_q;
    y_d = y_q;
    case (state_q)
      S_IDLE: if (start) begin
        x0_d = start_x;
        y0_d = start_y;
        w_d = width;
        h_d = height;
        mode_d = mode;
        colour_d = colour;
        busy_d = 1'b1;
        state_d = zero ? S_DONE : S_DRAW;
        done_d = zero;
        plot_d = !zero && visible;
        x_d = px[COORD_W-1:0];
        y_d = py[COORD_W-1:0];
      end
      S_DRAW: begin
        state_d = last ? S_DONE : S_DRAW;
        done_d = last;
        plot_d = !last && visible;
        x_d = last ? x_q : px[COORD_W-1:0];
        y_d = last ? y_q : py[COORD_W-1:0];
      end
      default: begin
        state_d = S_IDLE;
        busy_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      x0_q <= '0;
      y0_q <= '0;
      w_q <= '0;
      h_q <= '0;
      mode_q <= MODE_FILL;
      colour_q <= '0;
      busy_q <= 1'b0;
      plot_q <= 1'b0;
      done_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
    end else begin
      state_q <= state_d;
      x0_q <= x0_d;
      y0_q <= y0_d;
      w_q <= w_d;
      h_q <= h_d;
      mode_q <= mode_d;
      colour_q <= colour_d;
      busy_q <= busy_d;
      plot_q <= plot_d;
      done_q <= done_d;
      x_q <= x_d;
      y_q <= y_d;
    end
  end
  assign busy = busy_q;
  assign plot = plot_q;
  assign done = done_q;
  assign x_out = x_q;
  assign y_out = y_q;
  assign colour_out = colour_q;
endmodule
